// File: rtl/sobel_frame_capture.sv
// sobel_frame_capture
//   Captures one frame of 1-bit Sobel pixels and packs them into DATA_W-bit
//   words for a frame memory. Capture is armed by iCapture_en and starts on
//   the next vertical-sync assert edge. The frame ends on the DE falling edge
//   of line ROW-1, or is aborted early by another VS assert edge.
//
// Ports
//   iCLK         clock, rising edge
//   rst          synchronous reset, active high
//   iCapture_en  arms a capture (sampled in IDLE only)
//   iVGA_V_SYNC  vertical sync; asserted level set by VS_ACT
//   iVGA_DE      data enable; high = active pixel on iSobel_data
//   iSobel_data  1-bit pixel
//   oWr_en       one-cycle write strobe
//   oWr_addr     word address (sequential accepted-pixel count / DATA_W)
//   oWr_data     packed pixels, bit 0 = earliest pixel
//   oFrame_done  one-cycle pulse at frame end or abort
//   oFrame_err   error flag of the last finished frame, held until next start
//   oBusy        high while ARMED or CAPTURE
module sobel_frame_capture #(
   parameter int COL    = 30,
   parameter int ROW    = 30,
   parameter int DATA_W = 8,
   parameter int AW     = 7,
   parameter bit VS_ACT = 1'b0
) (
   input  logic              iCLK,
   input  logic              rst,
   input  logic              iCapture_en,
   input  logic              iVGA_V_SYNC,
   input  logic              iVGA_DE,
   input  logic              iSobel_data,
   output logic              oWr_en,
   output logic [AW-1:0]     oWr_addr,
   output logic [DATA_W-1:0] oWr_data,
   output logic              oFrame_done,
   output logic              oFrame_err,
   output logic              oBusy
);

   localparam int TOTAL = COL * ROW;
   localparam int PW    = $clog2(TOTAL + 1);
   localparam int XW    = $clog2(COL + 1);
   localparam int YW    = (ROW > 1) ? $clog2(ROW) : 1;
   localparam int BW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [XW-1:0] COL_X   = XW'(COL);
   localparam logic [YW-1:0] LAST_Y  = YW'(ROW - 1);
   localparam logic [PW-1:0] TOTAL_P = PW'(TOTAL);
   localparam logic [PW-1:0] DW_P    = PW'(DATA_W);
   localparam logic [BW-1:0] LAST_B  = BW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

   state_t            state, state_n;
   logic [XW-1:0]     x_cnt, x_n;
   logic [YW-1:0]     y_cnt, y_n;
   logic [PW-1:0]     pix_cnt, pix_n;
   logic [DATA_W-1:0] acc, acc_n;
   logic              err, err_n;
   logic              vs_q, de_q;

   logic              wr_en_n, done_n, ferr_n, busy_n;
   logic [AW-1:0]     addr_n;
   logic [DATA_W-1:0] data_n;

   logic              vs_now, vs_edge, de_fall;
   logic [BW-1:0]     bidx;
   logic [AW-1:0]     word_idx;

   // vs_q holds "VS was asserted" so reset leaves it deasserted regardless
   // of the active polarity.
   assign vs_now   = (iVGA_V_SYNC == VS_ACT);
   assign vs_edge  = vs_now & ~vs_q;
   assign de_fall  = de_q & ~iVGA_DE;
   assign bidx     = BW'(pix_cnt % DW_P);
   assign word_idx = AW'(pix_cnt / DW_P);

   always_ff @(posedge iCLK) begin
      if (rst) begin
         state       <= IDLE;
         x_cnt       <= '0;
         y_cnt       <= '0;
         pix_cnt     <= '0;
         acc         <= '0;
         err         <= 1'b0;
         vs_q        <= 1'b0;
         de_q        <= 1'b0;
         oWr_en      <= 1'b0;
         oWr_addr    <= '0;
         oWr_data    <= '0;
         oFrame_done <= 1'b0;
         oFrame_err  <= 1'b0;
         oBusy       <= 1'b0;
      end else begin
         state       <= state_n;
         x_cnt       <= x_n;
         y_cnt       <= y_n;
         pix_cnt     <= pix_n;
         acc         <= acc_n;
         err         <= err_n;
         vs_q        <= vs_now;
         de_q        <= iVGA_DE;
         oWr_en      <= wr_en_n;
         oWr_addr    <= addr_n;
         oWr_data    <= data_n;
         oFrame_done <= done_n;
         oFrame_err  <= ferr_n;
         oBusy       <= busy_n;
      end
   end

   always_comb begin
      state_n = state;
      x_n     = x_cnt;
      y_n     = y_cnt;
      pix_n   = pix_cnt;
      acc_n   = acc;
      err_n   = err;
      wr_en_n = 1'b0;
      addr_n  = oWr_addr;
      data_n  = oWr_data;
      done_n  = 1'b0;
      ferr_n  = oFrame_err;

      case (state)
         IDLE: begin
            if (iCapture_en) state_n = ARMED;
         end

         ARMED: begin
            if (vs_edge) begin
               state_n = CAPTURE;
               x_n     = '0;
               y_n     = '0;
               pix_n   = '0;
               acc_n   = '0;
               err_n   = 1'b0;
               ferr_n  = 1'b0;
            end
         end

         CAPTURE: begin
            if (vs_edge) begin
               // Early VS: abort, flush whatever is pending, flag the frame.
               if (bidx != '0) begin
                  wr_en_n = 1'b1;
                  addr_n  = word_idx;
                  data_n  = acc;
               end
               acc_n   = '0;
               done_n  = 1'b1;
               ferr_n  = 1'b1;
               state_n = IDLE;
            end else if (iVGA_DE) begin
               if (x_cnt < COL_X) begin
                  x_n = x_cnt + 1'b1;
                  if (pix_cnt < TOTAL_P) begin
                     acc_n[bidx] = iSobel_data;
                     pix_n       = pix_cnt + 1'b1;
                     if (bidx == LAST_B) begin
                        wr_en_n = 1'b1;
                        addr_n  = word_idx;
                        data_n  = acc_n;
                        acc_n   = '0;
                     end
                  end else begin
                     err_n = 1'b1;
                  end
               end else begin
                  err_n = 1'b1;
               end
            end else if (de_fall) begin
               // End of line: short or long lines only flag the error, the
               // address stream stays dense.
               if (x_cnt != COL_X) err_n = 1'b1;
               x_n = '0;
               if (y_cnt == LAST_Y) begin
                  if (bidx != '0) begin
                     wr_en_n = 1'b1;
                     addr_n  = word_idx;
                     data_n  = acc;
                  end
                  acc_n   = '0;
                  done_n  = 1'b1;
                  ferr_n  = err_n;
                  state_n = IDLE;
               end else begin
                  y_n = y_cnt + 1'b1;
               end
            end
         end

         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_sobel_frame_capture.sv
// Self-checking bench for sobel_frame_capture. Each frame's expected writes
// and done/err result are computed by a software packer and queued as the
// frame is driven; a negedge monitor pops and compares as the DUT emits.
module tb_sobel_frame_capture;

   localparam int COL = 30;
   localparam int ROW = 30;
   localparam int DW  = 8;
   localparam int AW  = 7;

   logic          iCLK = 1'b0;
   logic          rst = 1'b1;
   logic          iCapture_en = 1'b0;
   logic          iVGA_V_SYNC = 1'b1;
   logic          iVGA_DE = 1'b0;
   logic          iSobel_data = 1'b0;
   logic          oWr_en;
   logic [AW-1:0] oWr_addr;
   logic [DW-1:0] oWr_data;
   logic          oFrame_done;
   logic          oFrame_err;
   logic          oBusy;

   int n_chk = 0;
   int n_bad = 0;
   int wr_seen = 0;
   int done_seen = 0;
   bit busy_chk = 1'b0;

   logic [AW+DW-1:0] wq[$];
   bit               dq[$];
   logic [AW+DW-1:0] e;
   bit               de_exp;

   sobel_frame_capture #(.COL(COL), .ROW(ROW), .DATA_W(DW), .AW(AW), .VS_ACT(1'b0)) dut (
      .iCLK(iCLK), .rst(rst), .iCapture_en(iCapture_en), .iVGA_V_SYNC(iVGA_V_SYNC),
      .iVGA_DE(iVGA_DE), .iSobel_data(iSobel_data), .oWr_en(oWr_en), .oWr_addr(oWr_addr),
      .oWr_data(oWr_data), .oFrame_done(oFrame_done), .oFrame_err(oFrame_err), .oBusy(oBusy)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   function automatic bit pixf(input int pat, input int x, input int y);
      case (pat)
         0:       return 1'b1;
         1:       return bit'((x + y) % 2);
         default: return ((x * 7 + y * 13 + x * y) % 5) < 2;
      endcase
   endfunction

   // Scoreboard monitor.
   always @(negedge iCLK) begin
      if (!rst) begin
         if (busy_chk) begin
            chk("busy_after_done", int'(oBusy), 0);
            busy_chk = 1'b0;
         end
         if (oWr_en) begin
            wr_seen++;
            if (wq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
               e = wq.pop_front();
               chk("wr_addr", int'(oWr_addr), int'(e[AW+DW-1:DW]));
               chk("wr_data", int'(oWr_data), int'(e[DW-1:0]));
            end
         end
         if (oFrame_done) begin
            done_seen++;
            busy_chk = 1'b1;
            if (dq.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               de_exp = dq.pop_front();
               chk("done_err", int'(oFrame_err), int'(de_exp));
            end
         end
      end
   end

   // Drive one frame. sl/slen: one line of non-standard length.
   // abort_after>0: VS re-asserted after that many lines.
   // rst_after>0: reset pulsed after that many lines.
   task automatic run_frame(input int pat, input int sl, input int slen,
                            input int abort_after, input int rst_after, input bit en);
      int nl, cnt, nb, len, d0, w0;
      logic [DW-1:0] acc;
      bit err;
      nl = ROW;
      if (abort_after > 0) nl = abort_after;
      if (rst_after > 0) nl = rst_after;

      cnt = 0; nb = 0; acc = '0; err = (abort_after > 0);
      for (int y = 0; y < nl; y++) begin
         len = (y == sl) ? slen : COL;
         if (len != COL) err = 1'b1;
         for (int x = 0; x < len; x++) begin
            if (x < COL && cnt < COL * ROW) begin
               acc[nb] = pixf(pat, x, y);
               nb++; cnt++;
               if (nb == DW) begin
                  if (en) wq.push_back({AW'(cnt / DW - 1), acc});
                  acc = '0; nb = 0;
               end
            end else err = 1'b1;
         end
      end
      if (en && rst_after == 0) begin
         if (nb != 0) wq.push_back({AW'(cnt / DW), acc});
         dq.push_back(err);
      end

      d0 = done_seen; w0 = wr_seen;
      tick(); iCapture_en = en;
      tick(); iCapture_en = 1'b0;
      tick(); tick();
      iVGA_V_SYNC = 1'b0; tick(); tick();
      iVGA_V_SYNC = 1'b1; tick(); tick(); tick();

      for (int y = 0; y < nl; y++) begin
         len = (y == sl) ? slen : COL;
         for (int x = 0; x < len; x++) begin
            iVGA_DE = 1'b1; iSobel_data = pixf(pat, x, y); tick();
         end
         iVGA_DE = 1'b0; iSobel_data = 1'b0;
         for (int i = 0; i < 4; i++) tick();
         if (y == 0) chk(en ? "busy_capture" : "busy_idle", int'(oBusy), int'(en));
      end

      if (rst_after > 0) begin
         rst = 1'b1; tick();
         chk("rst_wr_en", int'(oWr_en), 0);
         chk("rst_addr", int'(oWr_addr), 0);
         chk("rst_data", int'(oWr_data), 0);
         chk("rst_done", int'(oFrame_done), 0);
         chk("rst_err", int'(oFrame_err), 0);
         chk("rst_busy", int'(oBusy), 0);
         rst = 1'b0;
         w0 = wr_seen;
         for (int y = nl; y < ROW; y++) begin
            for (int x = 0; x < COL; x++) begin
               iVGA_DE = 1'b1; iSobel_data = 1'b1; tick();
            end
            iVGA_DE = 1'b0; tick(); tick();
         end
         for (int i = 0; i < 10; i++) tick();
         chk("rst_no_writes", wr_seen - w0, 0);
         chk("rst_no_done", done_seen - d0, 0);
         chk("rst_wq_left", wq.size(), 0);
         wq.delete();
         return;
      end

      if (abort_after > 0) begin
         iVGA_V_SYNC = 1'b0; tick(); tick();
         iVGA_V_SYNC = 1'b1;
      end

      if (en) begin
         for (int i = 0; i < 50 && done_seen == d0; i++) tick();
         chk("done_count", done_seen - d0, 1);
         for (int i = 0; i < 5; i++) tick();
         chk("done_once", done_seen - d0, 1);
         chk("err_held", int'(oFrame_err), int'(err));
         chk("wq_left", wq.size(), 0);
         chk("dq_left", dq.size(), 0);
      end else begin
         for (int i = 0; i < 20; i++) tick();
         chk("noen_writes", wr_seen - w0, 0);
         chk("noen_done", done_seen - d0, 0);
      end
      wq.delete();
      dq.delete();
   endtask

   initial begin
      rst = 1'b1;
      tick(); tick();
      chk("reset_wr_en", int'(oWr_en), 0);
      chk("reset_addr", int'(oWr_addr), 0);
      chk("reset_data", int'(oWr_data), 0);
      chk("reset_done", int'(oFrame_done), 0);
      chk("reset_err", int'(oFrame_err), 0);
      chk("reset_busy", int'(oBusy), 0);
      rst = 1'b0;
      tick(); tick();

      run_frame(0, -1, COL, 0, 0, 1'b1);  // all ones: 113 writes, last 0x0F
      run_frame(1, -1, COL, 0, 0, 1'b1);  // checkerboard
      run_frame(0, 5, 28, 0, 0, 1'b1);    // short line 5: 898 pixels, err
      run_frame(2, -1, COL, 10, 0, 1'b1); // abort after 10 lines
      run_frame(1, 3, 31, 0, 0, 1'b1);    // long line 3: extra pixel dropped
      run_frame(0, -1, COL, 0, 0, 1'b0);  // never armed
      run_frame(2, -1, COL, 0, 5, 1'b1);  // reset mid-frame
      run_frame(2, -1, COL, 0, 0, 1'b1);  // clean frame after reset

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
      $fatal(1, "timeout");
   end

endmodule
